// File: rtl/datapath_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : datapath_seq                                                  |
// | Purpose  : Multi-cycle OSECPU datapath sequencer. Accepts one decoded    |
// |            instruction pair, then steps READ -> EXEC -> (MEM) -> WB and  |
// |            pulses done (and err on an undefined opcode or mem timeout).  |
// | Ports    : clk, reset_n (async, active low)                              |
// |            instr_valid/instr_ready, instr0/instr1 : instruction input    |
// |            busy, done, err                        : status               |
// |            ireg_* / preg_*                        : IReg / PReg files    |
// |            lbt_*                                  : label-table write    |
// |            alu_*                                  : external ALU         |
// |            mem_*                                  : data memory port     |
// | Config   : DATAPATH_SEQ_MEM_EN enables LMEM/SMEM through the MEM state;  |
// |            without it the mem port is tied off and LMEM/SMEM raise err.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//
// Instruction word layout (instr0):
//   [31:24] opcode  [23:16] field A  [15:8] field B  [7:0] field C
//   Register indices use the low IREG_AW bits of a field (IREG_AW <= 8).
//   imm16 = instr0[15:0]. OFS_W must not exceed DATA_W.
//
// Opcode map and operand use:
//   0x01 LBSET  lbid=imm16, typ=instr0[21:16], base=instr1[31:16], count=instr1[15:0]
//   0x02 LIMM16 rA = sext(imm16)          0x03 PLIMM pA = {lbid=imm16, ofs=0}
//   0x04 LIMM32 rA = sext(instr1)         0x05 CP    rA = rB
//   0x08 LMEM   rA = mem[pB]              0x09 SMEM  mem[pB] = rA
//   0x0E PADD   pA = pB + rC              0x0F PDIF  rA = pB.ofs - pC.ofs
//   0x10..0x19  rA = rB op rC (OR..SAR)   0x20..0x27 rA = cmp/tst(rB, rC)
module datapath_seq #(
  parameter int DATA_W      = 32,
  parameter int IREG_AW     = 6,
  parameter int LBID_W      = 12,
  parameter int OFS_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr0,
  input  logic [31:0]        instr1,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [IREG_AW-1:0] ireg_r0,
  output logic [IREG_AW-1:0] ireg_r1,
  output logic [IREG_AW-1:0] ireg_rw,
  input  logic [DATA_W-1:0]  ireg_d0,
  input  logic [DATA_W-1:0]  ireg_d1,
  output logic [DATA_W-1:0]  ireg_dw,
  output logic               ireg_we,
  output logic [IREG_AW-1:0] preg_p0,
  output logic [IREG_AW-1:0] preg_p1,
  output logic [IREG_AW-1:0] preg_pw,
  input  logic [LBID_W-1:0]  preg_lbid0,
  input  logic [LBID_W-1:0]  preg_lbid1,
  input  logic [OFS_W-1:0]   preg_ofs0,
  input  logic [OFS_W-1:0]   preg_ofs1,
  output logic [LBID_W-1:0]  preg_lbidw,
  output logic [OFS_W-1:0]   preg_ofsw,
  output logic               preg_we,
  output logic [LBID_W-1:0]  lbt_lbidw,
  output logic [5:0]         lbt_typw,
  output logic [15:0]        lbt_basew,
  output logic [15:0]        lbt_countw,
  output logic               lbt_we,
  output logic [DATA_W-1:0]  alu_d0,
  output logic [DATA_W-1:0]  alu_d1,
  output logic [3:0]         alu_op,
  output logic               alu_iscmp,
  input  logic [DATA_W-1:0]  alu_dout,
  output logic               mem_req,
  output logic               mem_we,
  output logic [LBID_W-1:0]  mem_lbid,
  output logic [OFS_W-1:0]   mem_ofs,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata
);

  localparam logic [7:0] c_op_lbset  = 8'h01;
  localparam logic [7:0] c_op_limm16 = 8'h02;
  localparam logic [7:0] c_op_plimm  = 8'h03;
  localparam logic [7:0] c_op_limm32 = 8'h04;
  localparam logic [7:0] c_op_cp     = 8'h05;
  localparam logic [7:0] c_op_lmem   = 8'h08;
  localparam logic [7:0] c_op_smem   = 8'h09;
  localparam logic [7:0] c_op_padd   = 8'h0E;
  localparam logic [7:0] c_op_pdif   = 8'h0F;
  localparam logic [3:0] c_alu_add   = 4'h4;
  localparam logic [3:0] c_alu_sub   = 4'h5;

  typedef enum logic [2:0] {IDLE, READ, EXEC, MEM, WB} state_t;

  // ---------------------------------------------------------------- helpers
  function automatic logic [DATA_W-1:0] f_sext32(input logic [31:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[(i < 32) ? i : 31];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] f_zext_ofs(input logic [OFS_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = (i < OFS_W) ? v[(i < OFS_W) ? i : 0] : 1'b0;
    return r;
  endfunction

  function automatic logic [LBID_W-1:0] f_lbid16(input logic [15:0] v);
    logic [LBID_W-1:0] r;
    for (int i = 0; i < LBID_W; i++) r[i] = (i < 16) ? v[(i < 16) ? i : 0] : 1'b0;
    return r;
  endfunction

  // IReg port 0 carries the store source for SMEM and the integer addend for PADD.
  function automatic logic [IREG_AW-1:0] f_ireg_r0(input logic [31:0] w);
    if (w[31:24] == c_op_smem)      return w[16 +: IREG_AW];
    else if (w[31:24] == c_op_padd) return w[0 +: IREG_AW];
    else                            return w[8 +: IREG_AW];
  endfunction

  // ------------------------------------------------------------------ state
  state_t              r_state;
  logic [31:0]         r_instr0;
  logic [31:0]         r_instr1;
  logic [DATA_W-1:0]   r_d0;
  logic [LBID_W-1:0]   r_lbid0;
  logic [OFS_W-1:0]    r_ofs0;

  // ----------------------------------------------------------------- decode
  logic [7:0]          w_opc;
  logic [IREG_AW-1:0]  w_fa;
  logic [15:0]         w_imm16;
  logic                w_is_alu;
  logic                w_is_cmp;
  logic                w_is_mem;
  logic                w_defined;
  logic [DATA_W-1:0]   w_res;

  assign w_opc    = r_instr0[31:24];
  assign w_fa     = r_instr0[16 +: IREG_AW];
  assign w_imm16  = r_instr0[15:0];
  assign w_is_alu = (w_opc >= 8'h10) && (w_opc <= 8'h19);
  assign w_is_cmp = (w_opc[7:3] == 5'b00100);

`ifdef DATAPATH_SEQ_MEM_EN
  localparam int c_tw = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  logic [c_tw-1:0] r_tmo;
  logic            w_unused;

  assign w_is_mem = (w_opc == c_op_lmem) || (w_opc == c_op_smem);
  assign w_res    = (r_state == MEM) ? mem_rdata : alu_dout;
  assign w_unused = ^{r_instr0, preg_lbid1};
`else
  logic w_unused;

  assign w_is_mem  = 1'b0;
  assign w_res     = alu_dout;
  assign mem_req   = 1'b0;
  assign mem_we    = 1'b0;
  assign mem_lbid  = '0;
  assign mem_ofs   = '0;
  assign mem_wdata = '0;
  assign w_unused  = ^{r_instr0, preg_lbid1, r_ofs0, mem_ack, mem_rdata};
`endif

  assign w_defined = w_is_alu || w_is_cmp || w_is_mem ||
                     (w_opc inside {c_op_lbset, c_op_limm16, c_op_plimm, c_op_limm32,
                                    c_op_cp, c_op_padd, c_op_pdif});

  // Transitions into WB (normal completion) and into/within MEM.
  logic w_to_wb;
  logic w_to_mem;
  always_comb begin
    w_to_wb  = (r_state == EXEC) && !w_is_mem;
    w_to_mem = (r_state == EXEC) && w_is_mem;
`ifdef DATAPATH_SEQ_MEM_EN
    if (r_state == MEM) begin
      w_to_wb  = mem_ack;
      w_to_mem = !mem_ack && (r_tmo != '0);
    end
`endif
  end

  // Writeback values loaded into the output registers on entry to WB.
  logic                w_wb_ireg_we;
  logic [IREG_AW-1:0]  w_wb_ireg_rw;
  logic [DATA_W-1:0]   w_wb_ireg_dw;
  logic                w_wb_preg_we;
  logic [IREG_AW-1:0]  w_wb_preg_pw;
  logic [LBID_W-1:0]   w_wb_preg_lbidw;
  logic [OFS_W-1:0]    w_wb_preg_ofsw;
  logic                w_wb_lbt_we;

  always_comb begin
    w_wb_ireg_we    = 1'b0;
    w_wb_ireg_rw    = '0;
    w_wb_ireg_dw    = '0;
    w_wb_preg_we    = 1'b0;
    w_wb_preg_pw    = '0;
    w_wb_preg_lbidw = '0;
    w_wb_preg_ofsw  = '0;
    w_wb_lbt_we     = 1'b0;
    if (w_is_alu || w_is_cmp || (w_opc == c_op_pdif) || (w_opc == c_op_lmem && w_is_mem)) begin
      w_wb_ireg_we = 1'b1;
      w_wb_ireg_rw = w_fa;
      w_wb_ireg_dw = w_res;
    end else if (w_opc == c_op_limm16) begin
      w_wb_ireg_we = 1'b1;
      w_wb_ireg_rw = w_fa;
      w_wb_ireg_dw = f_sext32({{16{w_imm16[15]}}, w_imm16});
    end else if (w_opc == c_op_limm32) begin
      w_wb_ireg_we = 1'b1;
      w_wb_ireg_rw = w_fa;
      w_wb_ireg_dw = f_sext32(r_instr1);
    end else if (w_opc == c_op_cp) begin
      w_wb_ireg_we = 1'b1;
      w_wb_ireg_rw = w_fa;
      w_wb_ireg_dw = r_d0;
    end else if (w_opc == c_op_padd) begin
      // Offset arithmetic wraps at OFS_W; the label stays that of the source pointer.
      w_wb_preg_we    = 1'b1;
      w_wb_preg_pw    = w_fa;
      w_wb_preg_lbidw = r_lbid0;
      w_wb_preg_ofsw  = w_res[OFS_W-1:0];
    end else if (w_opc == c_op_plimm) begin
      w_wb_preg_we    = 1'b1;
      w_wb_preg_pw    = w_fa;
      w_wb_preg_lbidw = f_lbid16(w_imm16);
    end else if (w_opc == c_op_lbset) begin
      w_wb_lbt_we = 1'b1;
    end
  end

  // ------------------------------------------------------------- sequencer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_instr0    <= '0;
      r_instr1    <= '0;
      r_d0        <= '0;
      r_lbid0     <= '0;
      r_ofs0      <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ireg_r0     <= '0;
      ireg_r1     <= '0;
      ireg_rw     <= '0;
      ireg_dw     <= '0;
      ireg_we     <= 1'b0;
      preg_p0     <= '0;
      preg_p1     <= '0;
      preg_pw     <= '0;
      preg_lbidw  <= '0;
      preg_ofsw   <= '0;
      preg_we     <= 1'b0;
      lbt_lbidw   <= '0;
      lbt_typw    <= '0;
      lbt_basew   <= '0;
      lbt_countw  <= '0;
      lbt_we      <= 1'b0;
      alu_d0      <= '0;
      alu_d1      <= '0;
      alu_op      <= '0;
      alu_iscmp   <= 1'b0;
`ifdef DATAPATH_SEQ_MEM_EN
      r_tmo       <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_lbid    <= '0;
      mem_ofs     <= '0;
      mem_wdata   <= '0;
`endif
    end else begin
      // Every output belongs to exactly one state; clear all, then re-assert
      // the ones the next state presents.
      instr_ready <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ireg_r0     <= '0;
      ireg_r1     <= '0;
      ireg_rw     <= '0;
      ireg_dw     <= '0;
      ireg_we     <= 1'b0;
      preg_p0     <= '0;
      preg_p1     <= '0;
      preg_pw     <= '0;
      preg_lbidw  <= '0;
      preg_ofsw   <= '0;
      preg_we     <= 1'b0;
      lbt_lbidw   <= '0;
      lbt_typw    <= '0;
      lbt_basew   <= '0;
      lbt_countw  <= '0;
      lbt_we      <= 1'b0;
      alu_d0      <= '0;
      alu_d1      <= '0;
      alu_op      <= '0;
      alu_iscmp   <= 1'b0;
`ifdef DATAPATH_SEQ_MEM_EN
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_lbid    <= '0;
      mem_ofs     <= '0;
      mem_wdata   <= '0;
`endif

      case (r_state)
        IDLE: begin
          if (instr_valid) begin
            r_instr0 <= instr0;
            r_instr1 <= instr1;
            r_state  <= READ;
            busy     <= 1'b1;
            ireg_r0  <= f_ireg_r0(instr0);
            ireg_r1  <= instr0[0 +: IREG_AW];
            preg_p0  <= instr0[8 +: IREG_AW];
            preg_p1  <= instr0[0 +: IREG_AW];
          end else begin
            instr_ready <= 1'b1;
          end
        end

        READ: begin
          r_d0    <= ireg_d0;
          r_lbid0 <= preg_lbid0;
          r_ofs0  <= preg_ofs0;
          r_state <= EXEC;
          busy    <= 1'b1;
          if (w_opc == c_op_padd) begin
            alu_d0 <= ireg_d0;
            alu_d1 <= f_zext_ofs(preg_ofs0);
            alu_op <= c_alu_add;
          end else if (w_opc == c_op_pdif) begin
            alu_d0 <= f_zext_ofs(preg_ofs0);
            alu_d1 <= f_zext_ofs(preg_ofs1);
            alu_op <= c_alu_sub;
          end else if (w_is_alu) begin
            alu_d0 <= ireg_d0;
            alu_d1 <= ireg_d1;
            alu_op <= w_opc[3:0];
          end else if (w_is_cmp) begin
            alu_d0    <= ireg_d0;
            alu_d1    <= ireg_d1;
            alu_op    <= {1'b0, w_opc[2:0]};
            alu_iscmp <= 1'b1;
          end
        end

        EXEC: begin
          busy    <= 1'b1;
          r_state <= w_is_mem ? MEM : WB;
`ifdef DATAPATH_SEQ_MEM_EN
          r_tmo   <= c_tw'(MEM_TIMEOUT - 1);
`endif
        end

`ifdef DATAPATH_SEQ_MEM_EN
        MEM: begin
          busy <= 1'b1;
          if (mem_ack) begin
            r_state <= WB;
          end else if (r_tmo == '0) begin
            // Timed out: complete with err and leave every write enable low.
            r_state <= WB;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            r_tmo <= r_tmo - c_tw'(1);
          end
        end
`endif

        WB: begin
          r_state     <= IDLE;
          instr_ready <= 1'b1;
        end

        default: begin
          r_state     <= IDLE;
          instr_ready <= 1'b1;
        end
      endcase

`ifdef DATAPATH_SEQ_MEM_EN
      if (w_to_mem) begin
        mem_req   <= 1'b1;
        mem_we    <= (w_opc == c_op_smem);
        mem_lbid  <= (r_state == READ) ? preg_lbid0 : r_lbid0;
        mem_ofs   <= (r_state == READ) ? preg_ofs0 : r_ofs0;
        mem_wdata <= (w_opc == c_op_smem) ? r_d0 : '0;
      end
`endif

      if (w_to_wb) begin
        done       <= 1'b1;
        err        <= !w_defined;
        ireg_we    <= w_wb_ireg_we;
        ireg_rw    <= w_wb_ireg_rw;
        ireg_dw    <= w_wb_ireg_dw;
        preg_we    <= w_wb_preg_we;
        preg_pw    <= w_wb_preg_pw;
        preg_lbidw <= w_wb_preg_lbidw;
        preg_ofsw  <= w_wb_preg_ofsw;
        lbt_we     <= w_wb_lbt_we;
        if (w_wb_lbt_we) begin
          lbt_lbidw  <= f_lbid16(w_imm16);
          lbt_typw   <= r_instr0[21:16];
          lbt_basew  <= r_instr1[31:16];
          lbt_countw <= r_instr1[15:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_datapath_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_datapath_seq                                               |
// | Purpose  : Directed self-checking bench for datapath_seq with an         |
// |            add/sub/xor ALU model and hand-computed expected values.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_datapath_seq;

  localparam int DATA_W  = 32;
  localparam int IREG_AW = 6;
  localparam int LBID_W  = 12;
  localparam int OFS_W   = 16;
  localparam int MEM_TO  = 8;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               instr_valid;
  logic               instr_ready;
  logic [31:0]        instr0, instr1;
  logic               busy, done, err;
  logic [IREG_AW-1:0] ireg_r0, ireg_r1, ireg_rw;
  logic [DATA_W-1:0]  ireg_d0, ireg_d1, ireg_dw;
  logic               ireg_we;
  logic [IREG_AW-1:0] preg_p0, preg_p1, preg_pw;
  logic [LBID_W-1:0]  preg_lbid0, preg_lbid1, preg_lbidw;
  logic [OFS_W-1:0]   preg_ofs0, preg_ofs1, preg_ofsw;
  logic               preg_we;
  logic [LBID_W-1:0]  lbt_lbidw;
  logic [5:0]         lbt_typw;
  logic [15:0]        lbt_basew, lbt_countw;
  logic               lbt_we;
  logic [DATA_W-1:0]  alu_d0, alu_d1, alu_dout;
  logic [3:0]         alu_op;
  logic               alu_iscmp;
  logic               mem_req, mem_we, mem_ack;
  logic [LBID_W-1:0]  mem_lbid;
  logic [OFS_W-1:0]   mem_ofs;
  logic [DATA_W-1:0]  mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // External ALU: ADD and SUB, everything else XOR.
  always_comb begin
    if (alu_op == 4'h4)      alu_dout = alu_d0 + alu_d1;
    else if (alu_op == 4'h5) alu_dout = alu_d0 - alu_d1;
    else                     alu_dout = alu_d0 ^ alu_d1;
  end

  datapath_seq #(
    .DATA_W(DATA_W), .IREG_AW(IREG_AW), .LBID_W(LBID_W), .OFS_W(OFS_W), .MEM_TIMEOUT(MEM_TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr0(instr0), .instr1(instr1),
    .busy(busy), .done(done), .err(err),
    .ireg_r0(ireg_r0), .ireg_r1(ireg_r1), .ireg_rw(ireg_rw),
    .ireg_d0(ireg_d0), .ireg_d1(ireg_d1), .ireg_dw(ireg_dw), .ireg_we(ireg_we),
    .preg_p0(preg_p0), .preg_p1(preg_p1), .preg_pw(preg_pw),
    .preg_lbid0(preg_lbid0), .preg_lbid1(preg_lbid1),
    .preg_ofs0(preg_ofs0), .preg_ofs1(preg_ofs1),
    .preg_lbidw(preg_lbidw), .preg_ofsw(preg_ofsw), .preg_we(preg_we),
    .lbt_lbidw(lbt_lbidw), .lbt_typw(lbt_typw), .lbt_basew(lbt_basew),
    .lbt_countw(lbt_countw), .lbt_we(lbt_we),
    .alu_d0(alu_d0), .alu_d1(alu_d1), .alu_op(alu_op), .alu_iscmp(alu_iscmp),
    .alu_dout(alu_dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_lbid(mem_lbid), .mem_ofs(mem_ofs),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one instruction; returns just after the accept edge (cycle 0).
  task automatic issue(input logic [31:0] i0, input logic [31:0] i1);
    @(negedge clk);
    instr0      = i0;
    instr1      = i1;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int req_cycles;
    logic seen;
    reset_n = 1'b0; instr_valid = 1'b0; instr0 = '0; instr1 = '0;
    ireg_d0 = '0; ireg_d1 = '0; preg_lbid0 = '0; preg_lbid1 = '0;
    preg_ofs0 = '0; preg_ofs1 = '0; mem_ack = 1'b0; mem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 64'(instr_ready), 64'd1);
    check_eq("rst_busy",  64'(busy),        64'd0);
    check_eq("rst_done",  64'(done),        64'd0);
    check_eq("rst_ireg_we", 64'(ireg_we),   64'd0);
    check_eq("rst_mem_req", 64'(mem_req),   64'd0);
    reset_n = 1'b1;

    // LIMM16 r5, 0xFFFE
    issue({8'h02, 8'd5, 16'hFFFE}, 32'h0);
    @(negedge clk);
    check_eq("limm16_busy",  64'(busy),        64'd1);
    check_eq("limm16_ready", 64'(instr_ready), 64'd0);
    @(negedge clk);
    check_eq("limm16_c2_done", 64'(done), 64'd0);
    @(negedge clk);
    check_eq("limm16_done", 64'(done),    64'd1);
    check_eq("limm16_err",  64'(err),     64'd0);
    check_eq("limm16_we",   64'(ireg_we), 64'd1);
    check_eq("limm16_rw",   64'(ireg_rw), 64'd5);
    check_eq("limm16_dw",   64'(ireg_dw), 64'hFFFF_FFFE);
    @(negedge clk);
    check_eq("limm16_c4_done",  64'(done),        64'd0);
    check_eq("limm16_c4_ready", 64'(instr_ready), 64'd1);

    // ADD r1 = r2 + r3; a new valid and a stray mem_ack while busy are ignored
    ireg_d0 = 32'd7; ireg_d1 = 32'd9;
    issue({8'h14, 8'd1, 8'd2, 8'd3}, 32'h0);
    instr0 = {8'hFF, 24'h0}; instr_valid = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    check_eq("add_r0", 64'(ireg_r0), 64'd2);
    check_eq("add_r1", 64'(ireg_r1), 64'd3);
    @(negedge clk);
    check_eq("add_op",    64'(alu_op),    64'd4);
    check_eq("add_iscmp", 64'(alu_iscmp), 64'd0);
    check_eq("add_d0",    64'(alu_d0),    64'd7);
    check_eq("add_d1",    64'(alu_d1),    64'd9);
    @(negedge clk);
    check_eq("add_we",  64'(ireg_we), 64'd1);
    check_eq("add_rw",  64'(ireg_rw), 64'd1);
    check_eq("add_dw",  64'(ireg_dw), 64'd16);
    check_eq("add_err", 64'(err),     64'd0);
    @(negedge clk);
    instr_valid = 1'b0; mem_ack = 1'b0;
    check_eq("add_busy_ignored", 64'(busy), 64'd0);

    // CMPL r4 = r2 < r3 (model returns 7^9)
    issue({8'h22, 8'd4, 8'd2, 8'd3}, 32'h0);
    @(negedge clk); @(negedge clk);
    check_eq("cmp_op",    64'(alu_op),    64'd2);
    check_eq("cmp_iscmp", 64'(alu_iscmp), 64'd1);
    @(negedge clk);
    check_eq("cmp_dw", 64'(ireg_dw), 64'hE);
    check_eq("cmp_rw", 64'(ireg_rw), 64'd4);

    // PADD p2 = p4 + r6, offset wraps
    ireg_d0 = 32'h20; preg_ofs0 = 16'hFFF0; preg_lbid0 = 12'd3;
    issue({8'h0E, 8'd2, 8'd4, 8'd6}, 32'h0);
    @(negedge clk);
    check_eq("padd_p0", 64'(preg_p0), 64'd4);
    check_eq("padd_r0", 64'(ireg_r0), 64'd6);
    @(negedge clk);
    check_eq("padd_op", 64'(alu_op), 64'd4);
    check_eq("padd_d1", 64'(alu_d1), 64'hFFF0);
    @(negedge clk);
    check_eq("padd_we",   64'(preg_we),    64'd1);
    check_eq("padd_pw",   64'(preg_pw),    64'd2);
    check_eq("padd_lbid", 64'(preg_lbidw), 64'd3);
    check_eq("padd_ofs",  64'(preg_ofsw),  64'h0010);
    check_eq("padd_iwe",  64'(ireg_we),    64'd0);

    // PDIF r7 = p1 - p2
    preg_ofs0 = 16'h0100; preg_ofs1 = 16'h0030;
    issue({8'h0F, 8'd7, 8'd1, 8'd2}, 32'h0);
    @(negedge clk); @(negedge clk);
    check_eq("pdif_op", 64'(alu_op), 64'd5);
    @(negedge clk);
    check_eq("pdif_dw", 64'(ireg_dw), 64'hD0);
    check_eq("pdif_rw", 64'(ireg_rw), 64'd7);

    // LIMM32 r9
    issue({8'h04, 8'd9, 16'h0}, 32'h8765_4321);
    repeat (3) @(negedge clk);
    check_eq("limm32_dw", 64'(ireg_dw), 64'h8765_4321);

    // LBSET
    issue({8'h01, 8'h2A, 16'h0ABC}, {16'h1000, 16'h0040});
    repeat (3) @(negedge clk);
    check_eq("lbset_we",    64'(lbt_we),     64'd1);
    check_eq("lbset_lbid",  64'(lbt_lbidw),  64'hABC);
    check_eq("lbset_typ",   64'(lbt_typw),   64'h2A);
    check_eq("lbset_base",  64'(lbt_basew),  64'h1000);
    check_eq("lbset_count", 64'(lbt_countw), 64'h0040);
    check_eq("lbset_iwe",   64'(ireg_we),    64'd0);

    // PLIMM p3
    issue({8'h03, 8'd3, 16'h0055}, 32'h0);
    repeat (3) @(negedge clk);
    check_eq("plimm_we",   64'(preg_we),    64'd1);
    check_eq("plimm_pw",   64'(preg_pw),    64'd3);
    check_eq("plimm_lbid", 64'(preg_lbidw), 64'h55);
    check_eq("plimm_ofs",  64'(preg_ofsw),  64'h0);

    // CP r8 = r2
    ireg_d0 = 32'h5A5A;
    issue({8'h05, 8'd8, 8'd2, 8'd0}, 32'h0);
    repeat (3) @(negedge clk);
    check_eq("cp_dw", 64'(ireg_dw), 64'h5A5A);
    check_eq("cp_rw", 64'(ireg_rw), 64'd8);

    // Undefined opcode
    issue({8'hFF, 24'h010203}, 32'h0);
    repeat (2) @(negedge clk);
    check_eq("undef_c2_done", 64'(done), 64'd0);
    @(negedge clk);
    check_eq("undef_done", 64'(done), 64'd1);
    check_eq("undef_err",  64'(err),  64'd1);
    check_eq("undef_we",   64'({ireg_we, preg_we, lbt_we}), 64'd0);

`ifdef DATAPATH_SEQ_MEM_EN
    // LMEM r10 = [p1], ack in the fifth MEM cycle
    preg_lbid0 = 12'h7; preg_ofs0 = 16'h0200; mem_rdata = 32'h1234;
    issue({8'h08, 8'd10, 8'd1, 8'd0}, 32'h0);
    repeat (2) @(negedge clk);
    req_cycles = 0;
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      if (mem_req) req_cycles++;
      if (k == 3) begin
        check_eq("lmem_lbid", 64'(mem_lbid), 64'h7);
        check_eq("lmem_ofs",  64'(mem_ofs),  64'h200);
        check_eq("lmem_mwe",  64'(mem_we),   64'd0);
      end
    end
    check_eq("lmem_req_cycles", 64'(req_cycles), 64'd5);
    check_eq("lmem_c7_done", 64'(done), 64'd0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("lmem_done", 64'(done),    64'd1);
    check_eq("lmem_err",  64'(err),     64'd0);
    check_eq("lmem_we",   64'(ireg_we), 64'd1);
    check_eq("lmem_rw",   64'(ireg_rw), 64'd10);
    check_eq("lmem_dw",   64'(ireg_dw), 64'h1234);
    check_eq("lmem_req_wb", 64'(mem_req), 64'd0);

    // SMEM with no ack: timeout after MEM_TO cycles
    ireg_d0 = 32'hCAFE;
    issue({8'h09, 8'd4, 8'd1, 8'd0}, 32'h0);
    @(negedge clk);
    check_eq("smem_r0", 64'(ireg_r0), 64'd4);
    @(negedge clk);
    req_cycles = 0;
    for (int k = 3; k <= 10; k++) begin
      @(negedge clk);
      if (mem_req) req_cycles++;
    end
    check_eq("smem_req_cycles", 64'(req_cycles), 64'd8);
    check_eq("smem_mwe",   64'(mem_we),    64'd1);
    check_eq("smem_wdata", 64'(mem_wdata), 64'hCAFE);
    @(negedge clk);
    check_eq("tmo_done", 64'(done), 64'd1);
    check_eq("tmo_err",  64'(err),  64'd1);
    check_eq("tmo_we",   64'({ireg_we, preg_we, lbt_we}), 64'd0);
    check_eq("tmo_req",  64'(mem_req), 64'd0);

    // Reset in the middle of MEM
    issue({8'h08, 8'd10, 8'd1, 8'd0}, 32'h0);
    repeat (4) @(negedge clk);
    check_eq("abort_req_before", 64'(mem_req), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("abort_req", 64'(mem_req), 64'd0);
`else
    // LMEM without the memory feature completes as undefined
    issue({8'h08, 8'd10, 8'd1, 8'd0}, 32'h0);
    repeat (3) @(negedge clk);
    check_eq("lmem_off_done", 64'(done),    64'd1);
    check_eq("lmem_off_err",  64'(err),     64'd1);
    check_eq("lmem_off_we",   64'(ireg_we), 64'd0);
    check_eq("lmem_off_req",  64'(mem_req), 64'd0);

    // Reset in the middle of EXEC
    issue({8'h14, 8'd1, 8'd2, 8'd3}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
`endif
    check_eq("abort_busy",  64'(busy),        64'd0);
    check_eq("abort_ready", 64'(instr_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | ireg_we | done;
    end
    check_eq("abort_no_wb",    64'(seen),        64'd0);
    check_eq("abort_ready_ok", 64'(instr_ready), 64'd1);

    // Recovery after the abort
    issue({8'h02, 8'd6, 16'h0123}, 32'h0);
    repeat (3) @(negedge clk);
    check_eq("recover_dw", 64'(ireg_dw), 64'h123);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
